bram_sdp_be: RTL and testbench
==============================

Name: bram_sdp_be

Overview:
- Parametrised successor to the team's simple dual-port block RAM: one write port, one read port, one clock.
- Adds per-byte write enables and a read-enable/valid handshake.
- Adds a selectable read latency of 1 or 2 cycles, using an optional output register.
- Adds a selectable read-during-write collision mode and an automatic memory clear after reset.
- Used as the generic on-chip buffer behind FIFOs, line buffers and coefficient stores.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 10, address width; depth = 2**ADDR_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH (derived).
- OUT_REG, 1, 0 = read latency 1; 1 = read latency 2 (extra output register).
- RDW_MODE, 0, same-address read/write collision: 0 = read-first (old data); 1 = write-first (new data).
- CLEAR_ON_RESET, 1, 1 = zero every word after reset release; 0 = no clear, contents retained.

Ports:
- clk, input, 1, clock; all logic on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- init_busy, output, 1, high while the clear sequence runs; ports are ignored while high.
- we, input, 1, write request.
- wr_be, input, NUM_BYTES, byte-lane write enables; lane i covers data bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- wr_addr, input, ADDR_WIDTH, write address.
- wr_data, input, DATA_WIDTH, write data.
- rd_en, input, 1, read request.
- rd_addr, input, ADDR_WIDTH, read address.
- rd_data, output, DATA_WIDTH, read data; holds its last value when no new read completes.
- rd_valid, output, 1, one-cycle pulse marking rd_data valid for the matching rd_en.

Behaviour:
- Reset values (rst_n low):
  - rd_data = 0, rd_valid = 0, pipeline valid bits = 0, clear address = 0.
  - init_busy = 1 if CLEAR_ON_RESET, else 0.
  - The memory array itself is never reset; it stays inferable as block RAM.
- FSM states: CLEAR, RUN.
  - Reset enters CLEAR if CLEAR_ON_RESET, else RUN.
  - In CLEAR, one word per cycle is written with all-zero data and all lanes enabled, at address 0 up to 2**ADDR_WIDTH-1.
  - After the write to the last address: transition to RUN; init_busy falls on that edge. Clear length is exactly 2**ADDR_WIDTH cycles after rst_n is released.
  - RUN is terminal until the next reset.
  - Reset asserted mid-clear or mid-read restarts from the reset values; the clear restarts at address 0.
- While in CLEAR: we and rd_en are ignored, no write occurs, and rd_valid stays 0.
- Write (RUN):
  - When we=1, each lane with wr_be[i]=1 is updated at the edge; other lanes are unchanged.
  - we=1 with wr_be all zero is a no-op.
- Read (RUN):
  - When rd_en=1, the address is sampled at edge N.
  - OUT_REG=0: rd_data and rd_valid update at edge N+1, i.e. latency 1.
  - OUT_REG=1: rd_data and rd_valid update at edge N+2, i.e. latency 2.
  - Back-to-back reads every cycle are fully pipelined; there are no stalls and no backpressure.
  - rd_valid is high exactly once per accepted rd_en.
- Collision (rd_en and we in the same cycle, rd_addr == wr_addr):
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the merged word (written lanes from wr_data, unwritten lanes from the old word). Implemented with a registered bypass of wr_data, wr_be and a hit flag.
  - Different addresses: no interaction.
- Address wrap: addresses are full-range with no bounds checking; the clear counter wraps only at the CLEAR exit.

Decomposition:
- Package bram_pkg holds:
  - rdw_mode_e (RDW_READ_FIRST = 0, RDW_WRITE_FIRST = 1).
  - clr_state_e (CLEAR, RUN).
  - A function computing NUM_BYTES.
- One sub-module, bram_clear_ctrl, contains the FSM and address counter. It outputs clr_we, clr_addr and init_busy, and the top-level write mux selects between the clear write and the user write.
- Memory array, collision bypass and output pipeline stay in the top level.

Test Plan:
1. Reset clear (ADDR_WIDTH=4, CLEAR_ON_RESET=1): release rst_n -> init_busy stays 1 for exactly 16 cycles. Then reading all 16 addresses returns 0x00000000, with rd_valid pulsed 16 times.
2. Byte enables: write 0xAABBCCDD at address 5 with wr_be=4'b1111, then write 0x11223344 at address 5 with wr_be=4'b0101 -> read of address 5 returns 0xAA22CC44.
3. Latency (OUT_REG=0 and 1): read address 5 with rd_en for one cycle -> rd_valid asserts exactly 1 cycle later for OUT_REG=0 and exactly 2 cycles later for OUT_REG=1, with rd_data = 0xAA22CC44 (following scenario 2).
4. Collision: address 3 holds 0x00000000. Same cycle: write 0xDEADBEEF with wr_be=4'b0011 and read address 3 -> RDW_MODE=0 returns 0x00000000; RDW_MODE=1 returns 0x0000BEEF.
5. Ignored during clear: drive we=1 to address 2 with 0xFFFFFFFF and rd_en=1 during CLEAR -> rd_valid never asserts, and address 2 reads 0 after the clear.
6. Mid-clear reset: assert rst_n low when the clear is at address 9 for 3 cycles, then release -> init_busy is high for a full 16 cycles and all addresses read 0. Also, streaming 16 consecutive reads produces 16 consecutive rd_valid pulses in order.

Source files
------------

// File: rtl/bram_pkg.sv
// Shared types and helpers for the byte-enable simple dual-port RAM.
// Imported by the clear controller and the RAM top level.
package bram_pkg;

    typedef enum logic {
        RDW_READ_FIRST  = 1'b0,
        RDW_WRITE_FIRST = 1'b1
    } rdw_mode_e;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } clr_state_e;

    function automatic int num_bytes(input int dw, input int bw);
        return dw / bw;
    endfunction

endpackage

// File: rtl/bram_clear_ctrl.sv
// Post-reset clear sequencer: walks every address once writing zero,
// then parks in RUN until the next reset.
module bram_clear_ctrl
    import bram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  init_busy
);

    localparam clr_state_e RST_STATE =
        (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE  = 1;

    clr_state_e            state;
    logic [ADDR_WIDTH-1:0] addr;

    // Step the clear address each cycle; leave CLEAR after the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            addr  <= '0;
        end else if (state == CLEAR) begin
            addr <= addr + ONE;
            if (addr == LAST) begin
                state <= RUN;
            end
        end
    end

    assign clr_we    = (state == CLEAR);
    assign clr_addr  = addr;
    assign init_busy = (state == CLEAR);

endmodule

// File: rtl/bram_sdp_be.sv
// Simple dual-port RAM with byte write enables, read valid handshake,
// 1 or 2 cycle read latency, collision mode and post-reset clear.
module bram_sdp_be
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTE_WIDTH     = 8,
    parameter int OUT_REG        = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NUM_BYTES     = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_busy,
    input  logic                  we,
    input  logic [NUM_BYTES-1:0]  wr_be,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int   DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic WR_FIRST = (RDW_MODE == int'(RDW_WRITE_FIRST));

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    logic                  user_we;
    logic                  rd_ok;
    logic                  mem_we;
    logic [NUM_BYTES-1:0]  mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;

    logic [DATA_WIDTH-1:0] rd_word;
    logic                  v1;
    logic                  hit;
    logic [DATA_WIDTH-1:0] byp_data;
    logic [NUM_BYTES-1:0]  byp_be;
    logic [DATA_WIDTH-1:0] merged;

    logic                  out_v;
    logic [DATA_WIDTH-1:0] out_d;

    bram_clear_ctrl #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_busy (init_busy)
    );

    assign user_we  = we & ~init_busy;
    assign rd_ok    = rd_en & ~init_busy;
    assign mem_we   = clr_we | user_we;
    assign mem_be   = clr_we ? '1 : wr_be;
    assign mem_addr = clr_we ? clr_addr : wr_addr;
    assign mem_data = clr_we ? '0 : wr_data;

    // Byte-lane write into the array; the array itself is never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (mem_we && mem_be[i]) begin
                mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                    mem_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Registered array read; sees the pre-write word on a collision.
    always_ff @(posedge clk) begin
        if (rd_ok) begin
            rd_word <= mem[rd_addr];
        end
    end

    // First read stage: valid bit plus write-first bypass capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            hit      <= 1'b0;
            byp_data <= '0;
            byp_be   <= '0;
        end else begin
            v1 <= rd_ok;
            if (rd_ok) begin
                hit      <= WR_FIRST & user_we & (rd_addr == wr_addr);
                byp_data <= wr_data;
                byp_be   <= wr_be;
            end
        end
    end

    // Overlay freshly written lanes onto the old word on a bypass hit.
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (hit && byp_be[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] =
                    byp_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                  v2;
            logic [DATA_WIDTH-1:0] d2;

            // Optional extra pipeline register for the longer latency.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) begin
                        d2 <= merged;
                    end
                end
            end

            assign out_v = v2;
            assign out_d = d2;
        end else begin : g_noreg
            assign out_v = v1;
            assign out_d = merged;
        end
    endgenerate

    // Output register: load on completed read, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= out_v;
            if (out_v) begin
                rd_data <= out_d;
            end
        end
    end

endmodule

// File: tb/tb_bram_sdp_be.sv
// Bench for bram_sdp_be: two instances (latency 1 read-first and
// latency 2 write-first) share stimulus; reads are scoreboarded.
module tb_bram_sdp_be;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [3:0]  wr_be;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;

    logic        init_busy0, init_busy1;
    logic [31:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic        w;
        logic [3:0]  be;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        r;
        logic [3:0]  ra;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    vec_t tbl[14];

    int tests;
    int fails;
    int cyc;
    int rel;
    bit in_rst;
    bit mon_on;

    bram_sdp_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .OUT_REG(0), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .init_busy(init_busy0),
        .we(we), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data0), .rd_valid(rd_valid0)
    );

    bram_sdp_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8),
        .OUT_REG(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .init_busy(init_busy1),
        .we(we), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data1), .rd_valid(rd_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    // Drive one cycle of stimulus; entered and left at #1 after posedge.
    task automatic op(input logic w, input logic [3:0] be,
                      input logic [3:0] wa, input logic [31:0] wd,
                      input logic r, input logic [3:0] ra,
                      input logic [31:0] e0v, input logic [31:0] e1v);
        we      = w;
        wr_be   = be;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = r;
        rd_addr = ra;
        if (r && !in_rst && cyc >= rel + 16) begin
            q0.push_back('{e0v, cyc + 2});
            q1.push_back('{e1v, cyc + 3});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            op(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
    endtask

    task automatic do_reset(input int hold);
        rst_n  = 1'b0;
        in_rst = 1'b1;
        mon_on = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        check("rst_rd_data0", rd_data0, 32'h0);
        check("rst_rd_data1", rd_data1, 32'h0);
        check("rst_rd_valid0", {31'h0, rd_valid0}, 32'h0);
        check("rst_rd_valid1", {31'h0, rd_valid1}, 32'h0);
        check("rst_busy0", {31'h0, init_busy0}, 32'h1);
        check("rst_busy1", {31'h0, init_busy1}, 32'h1);
        repeat (hold) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rel    = cyc;
        in_rst = 1'b0;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        cyc     = 0;
        rel     = 0;
        in_rst  = 1'b1;
        mon_on  = 1'b0;
        rst_n   = 1'b1;
        we      = 1'b0;
        wr_be   = 4'h0;
        wr_addr = 4'h0;
        wr_data = 32'h0;
        rd_en   = 1'b0;
        rd_addr = 4'h0;

        tbl[0]  = '{1'b1, 4'hF, 4'h5, 32'hAABBCCDD,
                    1'b0, 4'h0, 32'h0, 32'h0};
        tbl[1]  = '{1'b1, 4'h5, 4'h5, 32'h11223344,
                    1'b0, 4'h0, 32'h0, 32'h0};
        tbl[2]  = '{1'b0, 4'h0, 4'h0, 32'h0,
                    1'b1, 4'h5, 32'hAA22CC44, 32'hAA22CC44};
        tbl[3]  = '{1'b0, 4'h0, 4'h0, 32'h0,
                    1'b0, 4'h0, 32'h0, 32'h0};
        tbl[4]  = '{1'b1, 4'h3, 4'h3, 32'hDEADBEEF,
                    1'b1, 4'h3, 32'h00000000, 32'h0000BEEF};
        tbl[5]  = '{1'b0, 4'h0, 4'h0, 32'h0,
                    1'b1, 4'h3, 32'h0000BEEF, 32'h0000BEEF};
        tbl[6]  = '{1'b1, 4'h0, 4'h3, 32'hFFFFFFFF,
                    1'b1, 4'h7, 32'h0, 32'h0};
        tbl[7]  = '{1'b0, 4'h0, 4'h0, 32'h0,
                    1'b1, 4'h3, 32'h0000BEEF, 32'h0000BEEF};
        tbl[8]  = '{1'b1, 4'h8, 4'h3, 32'h12345678,
                    1'b1, 4'h3, 32'h0000BEEF, 32'h1200BEEF};
        tbl[9]  = '{1'b0, 4'h0, 4'h0, 32'h0,
                    1'b1, 4'h3, 32'h1200BEEF, 32'h1200BEEF};
        tbl[10] = '{1'b1, 4'hF, 4'hF, 32'h5A5A5A5A,
                    1'b1, 4'h5, 32'hAA22CC44, 32'hAA22CC44};
        tbl[11] = '{1'b0, 4'h0, 4'h0, 32'h0,
                    1'b1, 4'hF, 32'h5A5A5A5A, 32'h5A5A5A5A};
        tbl[12] = '{1'b1, 4'hC, 4'h0, 32'hCAFEF00D,
                    1'b1, 4'h0, 32'h00000000, 32'hCAFE0000};
        tbl[13] = '{1'b0, 4'h0, 4'h0, 32'h0,
                    1'b1, 4'h0, 32'hCAFE0000, 32'hCAFE0000};

        @(posedge clk);
        #1;

        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (mon_on) begin
                        logic bexp;
                        exp_t e;
                        bexp = in_rst || (cyc < rel + 16);
                        check("init_busy0", {31'h0, init_busy0},
                              {31'h0, bexp});
                        check("init_busy1", {31'h0, init_busy1},
                              {31'h0, bexp});
                        if (rd_valid0) begin
                            if (q0.size() == 0) begin
                                tests++;
                                fails++;
                                $display("FAIL rd_valid0: got 1 expected 0 (cycle %0d)", cyc);
                            end else begin
                                e = q0.pop_front();
                                check("rd_data0", rd_data0, e.data);
                                check("latency0", cyc, e.due);
                            end
                        end else if (q0.size() != 0 && q0[0].due <= cyc) begin
                            e = q0.pop_front();
                            tests++;
                            fails++;
                            $display("FAIL rd_valid0: got 0 expected 1 (due %0d)", e.due);
                        end
                        if (rd_valid1) begin
                            if (q1.size() == 0) begin
                                tests++;
                                fails++;
                                $display("FAIL rd_valid1: got 1 expected 0 (cycle %0d)", cyc);
                            end else begin
                                e = q1.pop_front();
                                check("rd_data1", rd_data1, e.data);
                                check("latency1", cyc, e.due);
                            end
                        end else if (q1.size() != 0 && q1[0].due <= cyc) begin
                            e = q1.pop_front();
                            tests++;
                            fails++;
                            $display("FAIL rd_valid1: got 0 expected 1 (due %0d)", e.due);
                        end
                    end
                end
            end
            begin : stimulus
                // Reset, then hammer the ports while the clear runs.
                do_reset(3);
                for (int i = 0; i < 16; i++) begin
                    op(1'b1, 4'hF, 4'h2, 32'hFFFFFFFF,
                       1'b1, 4'h2, 32'h0, 32'h0);
                end
                for (int a = 0; a < 16; a++) begin
                    op(1'b0, 4'h0, 4'h0, 32'h0,
                       1'b1, 4'(a), 32'h0, 32'h0);
                end
                idle(4);

                // Table: byte enables, latency, collisions.
                for (int i = 0; i < 14; i++) begin
                    op(tbl[i].w, tbl[i].be, tbl[i].wa, tbl[i].wd,
                       tbl[i].r, tbl[i].ra, tbl[i].e0, tbl[i].e1);
                end
                idle(5);
                check("hold_rd_data0", rd_data0, 32'hCAFE0000);
                check("hold_rd_data1", rd_data1, 32'hCAFE0000);

                // Reset with non-zero contents, abort the clear at 9.
                do_reset(2);
                idle(9);
                do_reset(3);
                idle(16);
                for (int a = 0; a < 16; a++) begin
                    op(1'b0, 4'h0, 4'h0, 32'h0,
                       1'b1, 4'(a), 32'h0, 32'h0);
                end
                idle(3);

                // Distinct words, then a 16-read back-to-back stream.
                for (int a = 0; a < 16; a++) begin
                    op(1'b1, 4'hF, 4'(a), {28'h0, 4'(a)} * 32'h11111111,
                       1'b0, 4'h0, 32'h0, 32'h0);
                end
                for (int a = 0; a < 16; a++) begin
                    op(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a),
                       {28'h0, 4'(a)} * 32'h11111111,
                       {28'h0, 4'(a)} * 32'h11111111);
                end
                idle(6);
                check("drain0", q0.size(), 32'h0);
                check("drain1", q1.size(), 32'h0);
            end
        join_any
        disable fork;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
